// File: rtl/uart_alu_sequencer_if.sv
// uart_alu_sequencer_if
// Handshake bundle between the UART block and the ALU sequencer.
//   rx_to_intf_done    : one-cycle pulse, received byte valid
//   rx_to_intf_data    : received byte
//   tx_to_intf_active  : transmitter busy
//   tx_to_intf_done    : one-cycle pulse, transmitted byte finished
//   tx_start           : one-cycle transmit request
//   intf_to_tx_result  : byte to transmit
// Modports: master = UART side, slave = sequencer side.
interface uart_alu_sequencer_if #(
    parameter int NB_DATA = 8
) ();
    logic               rx_to_intf_done;
    logic [NB_DATA-1:0] rx_to_intf_data;
    logic               tx_to_intf_active;
    logic               tx_to_intf_done;
    logic               tx_start;
    logic [NB_DATA-1:0] intf_to_tx_result;

    modport master (
        output rx_to_intf_done, rx_to_intf_data, tx_to_intf_active, tx_to_intf_done,
        input  tx_start, intf_to_tx_result
    );

    modport slave (
        input  rx_to_intf_done, rx_to_intf_data, tx_to_intf_active, tx_to_intf_done,
        output tx_start, intf_to_tx_result
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
// Collects operand A, operand B and opcode bytes from the UART receiver,
// drives the external combinational ALU, and sends the result (or ERR_CODE
// for an unsupported opcode) back through the UART transmitter.
// Ports:
//   i_Clock, i_reset  : clock, asynchronous active-high reset
//   uart              : UART handshake bundle (slave modport)
//   i_alu_result      : combinational ALU output
//   o_alu_a/b/op      : latched ALU operands and opcode
//   o_busy            : not in IDLE
//   o_err             : sticky invalid-opcode flag, cleared when A is accepted
//   o_overrun         : sticky flag, byte dropped while busy
// Optional macro UART_SEQ_TIMEOUT_EN: inter-byte timeout of TIMEOUT_CYCLES
// clocks in WAIT_B/WAIT_OP returns to IDLE; otherwise those states wait forever.
//
// state   | meaning
// IDLE    | waiting for operand A
// WAIT_B  | waiting for operand B
// WAIT_OP | waiting for opcode byte
// EXEC    | ALU settle cycle, result captured at its end
// SEND    | request transmission once the transmitter is idle
// WAIT_TX | waiting for the transmitter to finish
module uart_alu_sequencer #(
    parameter int               NB_DATA        = 8,
    parameter int               NB_OP          = 6,
    parameter logic [NB_DATA-1:0] ERR_CODE     = 8'hFF,
    parameter int               TIMEOUT_CYCLES = 50000
) (
    input  logic                 i_Clock,
    input  logic                 i_reset,
    uart_alu_sequencer_if.slave  uart,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_alu_a,
    output logic [NB_DATA-1:0]   o_alu_b,
    output logic [NB_OP-1:0]     o_alu_op,
    output logic                 o_busy,
    output logic                 o_err,
    output logic                 o_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    state_t             r_state, w_state_next;
    logic [NB_DATA-1:0] r_alu_a, w_alu_a_next;
    logic [NB_DATA-1:0] r_alu_b, w_alu_b_next;
    logic [NB_OP-1:0]   r_alu_op, w_alu_op_next;
    logic [NB_DATA-1:0] r_result, w_result_next;
    logic               r_err, w_err_next;
    logic               r_overrun, w_overrun_next;
    logic               w_tx_start;
    logic               w_timeout;
    logic [NB_OP-1:0]   w_rx_op;

    assign w_rx_op = uart.rx_to_intf_data[NB_OP-1:0];

    function automatic logic op_valid(input logic [NB_OP-1:0] op);
        case (op)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: op_valid = 1'b1;
            default:                                                op_valid = 1'b0;
        endcase
    endfunction

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int NB_TMO = $clog2(TIMEOUT_CYCLES + 1);

    logic [NB_TMO-1:0] r_tmo_cnt;
    logic              w_waiting;

    assign w_waiting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    // An arriving byte in the expiry cycle takes priority over the timeout.
    assign w_timeout = w_waiting && !uart.rx_to_intf_done &&
                       ((r_tmo_cnt + 1'b1) == NB_TMO'(TIMEOUT_CYCLES));

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            r_tmo_cnt <= '0;
        end else if (w_timeout || (uart.rx_to_intf_done &&
                     (w_waiting || r_state == ST_IDLE))) begin
            r_tmo_cnt <= '0;
        end else if (w_waiting) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_alu_a_next   = r_alu_a;
        w_alu_b_next   = r_alu_b;
        w_alu_op_next  = r_alu_op;
        w_result_next  = r_result;
        w_err_next     = r_err;
        w_overrun_next = r_overrun;
        w_tx_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (uart.rx_to_intf_done) begin
                    w_alu_a_next = uart.rx_to_intf_data;
                    w_err_next   = 1'b0;
                    w_state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (uart.rx_to_intf_done) begin
                    w_alu_b_next = uart.rx_to_intf_data;
                    w_state_next = ST_WAIT_OP;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_OP: begin
                if (uart.rx_to_intf_done) begin
                    w_alu_op_next = w_rx_op;
                    if (op_valid(w_rx_op)) begin
                        w_state_next = ST_EXEC;
                    end else begin
                        w_result_next = ERR_CODE;
                        w_err_next    = 1'b1;
                        w_state_next  = ST_SEND;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Operands were registered last cycle, so the ALU output is settled now.
                w_result_next = i_alu_result;
                w_state_next  = ST_SEND;
            end
            ST_SEND: begin
                if (!uart.tx_to_intf_active) begin
                    w_tx_start   = 1'b1;
                    w_state_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (uart.tx_to_intf_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (uart.rx_to_intf_done &&
            (r_state == ST_EXEC || r_state == ST_SEND || r_state == ST_WAIT_TX)) begin
            w_overrun_next = 1'b1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_alu_a   <= w_alu_a_next;
            r_alu_b   <= w_alu_b_next;
            r_alu_op  <= w_alu_op_next;
            r_result  <= w_result_next;
            r_err     <= w_err_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign o_alu_a                = r_alu_a;
    assign o_alu_b                = r_alu_b;
    assign o_alu_op               = r_alu_op;
    assign o_err                  = r_err;
    assign o_overrun              = r_overrun;
    assign o_busy                 = (r_state != ST_IDLE);
    assign uart.tx_start          = w_tx_start;
    assign uart.intf_to_tx_result = r_result;

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Sits between the `uart` block and the combinational ALU inside `top`.
- Collects three received bytes in order (operand A, operand B, opcode) and drives the ALU.
- Latches the ALU result and commands the UART transmitter to send it back as one byte.
- Rejects unsupported opcodes with a fixed error byte and flags bytes dropped while busy.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and result.
- NB_OP, 6, width of the ALU opcode; taken from the low NB_OP bits of the opcode byte.
- ERR_CODE, 8'hFF, byte transmitted in place of a result when the opcode is invalid.
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clocks; used only with the optional feature.

Ports:
- i_Clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- rx_to_intf_done  in  1  one-cycle pulse: a received byte is valid on rx_to_intf_data.
- rx_to_intf_data  in  NB_DATA  received byte.
- tx_to_intf_active  in  1  transmitter busy.
- tx_to_intf_done  in  1  one-cycle pulse: the transmitted byte has finished.
- i_alu_result  in  NB_DATA  combinational ALU output.
- o_alu_a  out  NB_DATA  latched operand A.
- o_alu_b  out  NB_DATA  latched operand B.
- o_alu_op  out  NB_OP  latched opcode.
- tx_start  out  1  one-cycle transmit request.
- intf_to_tx_result  out  NB_DATA  byte to transmit.
- o_busy  out  1  high in any state other than IDLE.
- o_err  out  1  sticky invalid-opcode flag.
- o_overrun  out  1  sticky dropped-byte flag.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous and aborts any operation at any point, including mid-transmission.
- IDLE:
  - On rx_to_intf_done: o_alu_a <= rx_to_intf_data, go to WAIT_B.
  - Accepting A clears o_err.
- WAIT_B: on rx_to_intf_done, o_alu_b <= data, go to WAIT_OP.
- WAIT_OP: on rx_to_intf_done, o_alu_op <= data[NB_OP-1:0].
  - Valid opcode set: 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR, 6'h03 SRA, 6'h02 SRL.
  - Valid opcode: go to EXEC.
  - Otherwise: intf_to_tx_result <= ERR_CODE, o_err <= 1, go to SEND.
- EXEC: one settle cycle, then intf_to_tx_result <= i_alu_result, go to SEND.
- SEND:
  - If tx_to_intf_active is low: tx_start = 1 for exactly this cycle, go to WAIT_TX.
  - Otherwise stay in SEND with tx_start low.
- WAIT_TX: on tx_to_intf_done, go to IDLE.
- Latency:
  - Opcode pulse to tx_start is 2 clocks (WAIT_OP→EXEC→SEND) when the transmitter is idle.
  - Invalid opcode: 1 clock.
- Bytes arriving while busy: rx_to_intf_done in EXEC, SEND or WAIT_TX drops the byte and sets o_overrun (sticky until reset). The dropped byte is never used as the next operand A.
- Hold rules:
  - o_alu_a, o_alu_b and o_alu_op hold until overwritten by the next accepted byte of the same role.
  - intf_to_tx_result holds until the next EXEC or invalid-opcode event.
- tx_start is never asserted outside SEND and never for more than one cycle per result.
- tx_to_intf_done outside WAIT_TX is ignored.

Optional Feature:
- Macro: UART_SEQ_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on every accepted byte and increments each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, discard partial operands (o_alu_a/o_alu_b keep their values but are no longer considered valid), clear the counter.
  - If rx_to_intf_done arrives in the same cycle as expiry, the byte wins: it is accepted normally and the timeout does not fire.
- Undefined: no counter; WAIT_B and WAIT_OP wait indefinitely.

Test Plan:
- Bytes 22, 18, 8'h20 with transmitter idle → o_alu_a=22, o_alu_b=18, o_alu_op=6'h20; tx_start one cycle, 2 clocks after the 3rd pulse; intf_to_tx_result=40; o_err=0.
- Bytes 8'h0F, 8'h01, 8'h22, then 8'hF0, 8'h0F, 8'h25 → results 14 then 8'hFF; exactly two tx_start pulses.
- Bytes 5, 3, 8'h3F → tx_start with intf_to_tx_result=8'hFF, o_err=1. A following byte 7 accepted as A clears o_err.
- tx_to_intf_active held high during the opcode pulse and 10 cycles after → stays in SEND with tx_start low; tx_start fires the first cycle active drops.
- Extra byte 9 while in WAIT_TX → o_overrun=1. Next sequence 1, 2, 8'h20 yields 3, proving 9 was discarded.
- Reset asserted in WAIT_OP → all outputs 0 and IDLE immediately.
- With UART_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100: byte A, then silence for 100 cycles → o_busy=0. Next 3 bytes 4, 4, 8'h20 → result 8.
